dut: RTL and testbench
======================

# dut

NAND flash controller core with an integrated, parameter-sized flash array and a single byte-wide page buffer. The host loads or unloads the page buffer through a byte port and issues page read, page program, block erase, reset and read-ID commands through a start/done handshake. The block is the top-level design below the verification harness and has no external flash pins.

## Interface
- PAGE_BYTES, 16: bytes per page; power of two.
- PAGES_PER_BLOCK, 4: pages per erase block; power of two.
- NUM_PAGES, 64: pages in the array; multiple of PAGES_PER_BLOCK.
- clk  in  1  clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- buf_in  in  8  host write data for the page buffer.
- buf_sel  in  1  host owns the page buffer while high.
- buf_we  in  1  write buf_in at the buffer pointer.
- buf_re  in  1  read the byte at the buffer pointer onto buf_out.
- buf_out  out  8  registered buffer read data.
- nfc_cmd  in  3  command code, sampled with nfc_start.
- RWA  in  16  row (page) address, sampled with nfc_start.
- nfc_start  in  1  command request.
- nfc_done  out  1  one-cycle completion pulse.
- command_error  out  1  error flag for the last command.

## Operation
- Commands:
  - 3'b001: page read, array page RWA -> buffer.
  - 3'b010: page program, array[RWA][i] &= buffer[i]. Bits only clear.
  - 3'b011: block erase, all pages of block RWA/PAGES_PER_BLOCK set to 8'hFF.
  - 3'b100: reset. Array unchanged; buffer pointer cleared.
  - 3'b101: read ID. Buffer bytes 0..3 = EC, DA, 10, 95; remaining bytes = 00.
  - Any other code: invalid.
- Address rule: RWA >= NUM_PAGES on read, program or erase is an error. The command completes without touching the array or the buffer and sets command_error.
- Erase address: RWA need not be block-aligned; the low bits are ignored.
- Array storage:
  - Initialized to 8'hFF at simulation start.
  - Not affected by Reset.
- FSM states: IDLE, XFER (one buffer byte per cycle), ERASE (one array byte per cycle), DONE.
  - IDLE -> XFER on read, program or read ID.
  - IDLE -> ERASE on erase.
  - IDLE -> DONE on reset, invalid or out-of-range commands.
  - XFER or ERASE -> DONE when the last byte is handled.
  - DONE -> IDLE, pulsing nfc_done.
- nfc_start is accepted only in IDLE and is ignored while busy.
- command_error:
  - Set at DONE of a failing command.
  - Cleared when the next command is accepted.
  - Otherwise held.
- Host buffer port, active only when buf_sel=1 and the FSM is in IDLE:
  - buf_we writes buf[ptr] and increments ptr.
  - buf_re loads buf_out <= buf[ptr] and increments ptr.
  - buf_we and buf_re together: the write wins and ptr increments once.
  - ptr wraps from PAGE_BYTES-1 to 0.
- Buffer pointer clearing: ptr clears to 0 on command acceptance, on nfc_done, and while buf_sel=0.
- Buffer accesses while busy are ignored; buf_out holds its value.

## Timing
- Reset: on a rising edge with Reset=1:
  - FSM goes to IDLE and ptr = 0.
  - buf_out, nfc_done and command_error all go to 0.
  - Reset mid-command aborts the command. Array bytes already written stay written, with no done pulse.
- Latency is measured from the edge sampling nfc_start (cycle 0) to the cycle in which nfc_done is high:
  - Read, program, read ID: PAGE_BYTES+2 (18 by default).
  - Erase: PAGES_PER_BLOCK*PAGE_BYTES+2 (66 by default).
  - Reset, invalid and out-of-range commands: 2.
- nfc_done is high for exactly one cycle.
- command_error is valid in the nfc_done cycle.
- A new nfc_start is accepted in the cycle after nfc_done.
- buf_out has one-cycle latency: data appears the cycle after buf_re is sampled.

## Configuration
- NFC_READ_ID_EN:
  - Defined: command 3'b101 performs read ID as specified.
  - Undefined: 3'b101 is treated as invalid (2-cycle completion, command_error=1) and the ID logic is removed.

## Test plan
- Reset, then idle: buf_out=00, nfc_done=0, command_error=0. Read page 5 -> nfc_done at cycle 18; buffer reads back 16×FF.
- Write buffer 00..0F, program page 3 (done at cycle 18), clear buffer, read page 3 -> 00..0F, command_error=0.
- Program page 3 again with 16×FF, then read page 3 -> still 00..0F (AND semantics). Erase RWA=2 -> done at cycle 66; read page 3 -> 16×FF.
- nfc_cmd=3'b111 -> nfc_done and command_error at cycle 2. Read with RWA=64 -> error, buffer unchanged. The next valid command clears command_error at acceptance.
- Read ID -> buffer EC DA 10 95 00…; with NFC_READ_ID_EN undefined -> command_error at cycle 2.
- Boundaries, each producing the stated effect:
  - nfc_start while busy: no effect.
  - Buffer access while busy: no effect.
  - buf_we+buf_re together: a single write.
  - 17 writes: byte 0 is overwritten.
  - Reset asserted at cycle 8 of an erase: no nfc_done, FSM in IDLE.

Source files
------------

// File: rtl/dut.sv
// dut: NAND flash controller core with on-chip array and a byte-wide page buffer.
// The read-ID command (3'b101) exists only when NFC_READ_ID_EN is defined.
module dut #(
    parameter int PAGE_BYTES      = 16,
    parameter int PAGES_PER_BLOCK = 4,
    parameter int NUM_PAGES       = 64
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [7:0]  buf_in,
    input  logic        buf_sel,
    input  logic        buf_we,
    input  logic        buf_re,
    output logic [7:0]  buf_out,
    input  logic [2:0]  nfc_cmd,
    input  logic [15:0] RWA,
    input  logic        nfc_start,
    output logic        nfc_done,
    output logic        command_error
);
    localparam int PW = $clog2(PAGE_BYTES);
    localparam int BB = PAGES_PER_BLOCK * PAGE_BYTES;
    localparam int IW = $clog2(BB);
    localparam int NW = $clog2(NUM_PAGES);
    localparam int AW = $clog2(NUM_PAGES * PAGE_BYTES);
    typedef enum logic [1:0] {IDLE, XFER, ERASE, DONE} state_t;
    state_t state;
    logic [2:0] cmd_r;
    logic [NW-1:0] page_r;
    logic [IW-1:0] idx;
    logic [PW-1:0] ptr, bi;
    logic err_r, id_cmd, rw_ok, bad, prog, host, mem_we;
    logic [7:0] id_byte;
    logic [AW-1:0] addr;
    logic [7:0] pbuf [PAGE_BYTES];
    logic [7:0] mem [NUM_PAGES*PAGE_BYTES] = '{default: 8'hFF};
`ifdef NFC_READ_ID_EN
    localparam logic [31:0] ID = 32'hECDA1095;
    assign id_cmd = nfc_cmd == 3'b101;
    assign id_byte = int'(bi) < 4 ? ID[8*(3 - int'(bi[1:0])) +: 8] : 8'h00;
`else
    assign id_cmd = 1'b0;
    assign id_byte = 8'h00;
`endif
    always_comb begin
        bi = idx[PW-1:0];
        rw_ok = nfc_cmd inside {3'b001, 3'b010, 3'b011} && int'(RWA) < NUM_PAGES;
        bad = !(rw_ok || id_cmd || nfc_cmd == 3'b100);
        prog = cmd_r == 3'b010;
        host = !Reset && state == IDLE && buf_sel;
        mem_we = !Reset && (state == ERASE || (state == XFER && prog));
        addr = state == ERASE ? AW'(int'(page_r) / PAGES_PER_BLOCK * BB + int'(idx))
                              : AW'(int'(page_r) * PAGE_BYTES + int'(bi));
    end
    // Host writes only happen in IDLE, so they never collide with transfer writes.
    always_ff @(posedge clk) begin
        if (host && buf_we)
            pbuf[ptr] <= buf_in;
        else if (!Reset && state == XFER && !prog)
            pbuf[bi] <= cmd_r == 3'b001 ? mem[addr] : id_byte;
    end
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= state == ERASE ? 8'hFF : mem[addr] & pbuf[bi];
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            ptr <= '0;
            buf_out <= 8'h00;
            nfc_done <= 1'b0;
            command_error <= 1'b0;
        end else begin
            nfc_done <= 1'b0;
            if (!buf_sel)
                ptr <= '0;
            case (state)
                IDLE: begin
                    if (host && buf_re && !buf_we)
                        buf_out <= pbuf[ptr];
                    if (nfc_start) begin
                        cmd_r <= nfc_cmd;
                        page_r <= NW'(RWA);
                        idx <= '0;
                        ptr <= '0;
                        err_r <= bad;
                        command_error <= 1'b0;
                        state <= bad || nfc_cmd == 3'b100 ? DONE : nfc_cmd == 3'b011 ? ERASE : XFER;
                    end else if (host && (buf_we || buf_re))
                        ptr <= ptr + 1'b1;
                end
                XFER: begin
                    idx <= idx + 1'b1;
                    if (idx == IW'(PAGE_BYTES - 1))
                        state <= DONE;
                end
                ERASE: begin
                    idx <= idx + 1'b1;
                    if (idx == IW'(BB - 1))
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    nfc_done <= 1'b1;
                    command_error <= err_r;
                    ptr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dut.sv
// tb_dut: randomized self-checking bench for dut against a page/block-level reference model.
module tb_dut;
    localparam int PB = 16, PPB = 4, NP = 64;
`ifdef NFC_READ_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    logic [7:0] buf_in = '0, buf_out;
    logic buf_sel = 0, buf_we = 0, buf_re = 0, nfc_start = 0, nfc_done, command_error;
    logic [2:0] nfc_cmd = '0;
    logic [15:0] rwa = '0;
    logic [7:0] m [NP*PB];
    logic [7:0] b [PB];
    logic [7:0] ebo;
    logic [7:0] idv [4] = '{8'hEC, 8'hDA, 8'h10, 8'h95};
    logic [2:0] inv [3] = '{3'b000, 3'b110, 3'b111};
    int hp, errs = 0, checks = 0;

    always #5 clk = ~clk;

    dut u_dut (
        .clk(clk), .Reset(rst), .buf_in(buf_in), .buf_sel(buf_sel), .buf_we(buf_we),
        .buf_re(buf_re), .buf_out(buf_out), .nfc_cmd(nfc_cmd), .RWA(rwa),
        .nfc_start(nfc_start), .nfc_done(nfc_done), .command_error(command_error)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic host_open;
        buf_sel = 0;
        tick;
        buf_sel = 1;
        hp = 0;
    endtask

    task automatic hwrite(input logic [7:0] d, input bit both);
        buf_in = d;
        buf_we = 1;
        buf_re = both;
        tick;
        buf_we = 0;
        buf_re = 0;
        b[hp] = d;
        hp = (hp + 1) % PB;
        if (both) check("we_re_out_hold", buf_out, ebo);
    endtask

    task automatic fill(input int n, input bit zero);
        host_open;
        for (int i = 0; i < n; i++) hwrite(zero ? 8'h00 : 8'($urandom), $urandom_range(0, 7) == 0);
        buf_sel = 0;
    endtask

    task automatic readback;
        host_open;
        for (int i = 0; i < PB; i++) begin
            buf_re = 1;
            tick;
            buf_re = 0;
            ebo = b[hp];
            check($sformatf("buf[%0d]", hp), buf_out, ebo);
            hp = (hp + 1) % PB;
        end
        buf_sel = 0;
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [15:0] a, input bit disturb);
        int lat, exp_lat, base;
        bit ok, id, err;
        ok = c inside {3'b001, 3'b010, 3'b011} && int'(a) < NP;
        id = c == 3'b101 && ID_EN;
        err = !(ok || id || c == 3'b100);
        exp_lat = ok ? (c == 3'b011 ? PPB*PB + 2 : PB + 2) : id ? PB + 2 : 2;
        buf_sel = 0;
        nfc_cmd = c;
        rwa = a;
        nfc_start = 1;
        tick;
        nfc_start = 0;
        check("err_clear_on_accept", command_error, 0);
        lat = 1;
        while (!nfc_done && lat < 200) begin
            if (disturb && lat == 3) begin
                nfc_start = 1; nfc_cmd = 3'b011; rwa = '0;
                buf_sel = 1; buf_we = 1; buf_re = 1; buf_in = 8'h5A;
            end else if (disturb && lat == 5) begin
                nfc_start = 0; buf_sel = 0; buf_we = 0; buf_re = 0;
            end
            tick;
            lat++;
        end
        nfc_start = 0; buf_sel = 0; buf_we = 0; buf_re = 0;
        check($sformatf("latency_cmd%0d", c), lat, exp_lat);
        check($sformatf("error_cmd%0d", c), command_error, err);
        check("buf_out_hold_busy", buf_out, ebo);
        tick;
        check("done_one_cycle", nfc_done, 0);
        check("error_held", command_error, err);
        if (ok && c == 3'b001) for (int i = 0; i < PB; i++) b[i] = m[int'(a)*PB + i];
        if (ok && c == 3'b010) for (int i = 0; i < PB; i++) m[int'(a)*PB + i] &= b[i];
        if (ok && c == 3'b011) begin
            base = (int'(a) / PPB) * PPB * PB;
            for (int i = 0; i < PPB*PB; i++) m[base + i] = 8'hFF;
        end
        if (id) for (int i = 0; i < PB; i++) b[i] = i < 4 ? idv[i] : 8'h00;
    endtask

    initial begin
        bit sd;
        int r;
        for (int i = 0; i < NP*PB; i++) m[i] = 8'hFF;
        for (int i = 0; i < PB; i++) b[i] = 8'h00;
        ebo = 8'h00;
        rst = 1;
        tick; tick;
        rst = 0;
        check("rst_buf_out", buf_out, 0);
        check("rst_done", nfc_done, 0);
        check("rst_error", command_error, 0);
        do_cmd(3'b001, 16'd5, 0);
        readback;
        host_open;
        for (int i = 0; i < PB; i++) hwrite(8'(i), 0);
        buf_sel = 0;
        do_cmd(3'b010, 16'd3, 0);
        fill(PB, 1);
        do_cmd(3'b001, 16'd3, 0);
        readback;
        host_open;
        for (int i = 0; i < PB; i++) hwrite(8'hFF, 0);
        buf_sel = 0;
        do_cmd(3'b010, 16'd3, 0);
        do_cmd(3'b001, 16'd3, 0);
        readback;
        do_cmd(3'b011, 16'd2, 0);
        do_cmd(3'b001, 16'd3, 0);
        readback;
        do_cmd(3'b111, 16'd0, 0);
        fill(PB, 0);
        do_cmd(3'b001, 16'd64, 0);
        readback;
        do_cmd(3'b001, 16'd0, 0);
        do_cmd(3'b101, 16'd0, 0);
        readback;
        fill(PB, 0);
        do_cmd(3'b010, 16'd0, 0);
        fill(PB, 0);
        do_cmd(3'b010, 16'd7, 0);
        do_cmd(3'b001, 16'd7, 1);
        readback;
        do_cmd(3'b001, 16'd0, 0);
        readback;
        host_open;
        hwrite(8'hA5, 1);
        hwrite(8'h3C, 0);
        buf_sel = 0;
        readback;
        fill(PB + 1, 0);
        readback;
        fill(PB, 1);
        do_cmd(3'b010, 16'd8, 0);
        nfc_cmd = 3'b011;
        rwa = 16'd9;
        nfc_start = 1;
        tick;
        nfc_start = 0;
        for (int k = 1; k < 8; k++) tick;
        rst = 1;
        tick;
        rst = 0;
        ebo = 8'h00;
        sd = 0;
        for (int k = 0; k < 6; k++) begin
            if (nfc_done) sd = 1;
            tick;
        end
        check("rst_mid_erase_no_done", sd, 0);
        check("rst_mid_erase_error", command_error, 0);
        check("rst_mid_erase_buf_out", buf_out, ebo);
        do_cmd(3'b011, 16'd9, 0);
        do_cmd(3'b001, 16'd8, 0);
        readback;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                do_cmd(3'b001, $urandom_range(0, 9) == 0 ? 16'($urandom_range(NP, 65535)) : 16'($urandom_range(0, NP-1)), 0);
                readback;
            end else if (r <= 4) begin
                fill($urandom_range(1, 20), 0);
                do_cmd(3'b010, 16'($urandom_range(0, NP-1)), 0);
            end else if (r == 5) do_cmd(3'b011, 16'($urandom_range(0, NP + 3)), 0);
            else if (r == 6) begin
                do_cmd(3'b101, 16'($urandom), 0);
                readback;
            end else if (r == 7) do_cmd(3'b100, 16'($urandom), 0);
            else if (r == 8) do_cmd(inv[$urandom_range(0, 2)], 16'($urandom), 0);
            else fill($urandom_range(1, 20), 0);
        end
        for (int p = 0; p < NP; p += 9) begin
            do_cmd(3'b001, 16'(p), 0);
            readback;
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
